usr_seq: RTL

USR_SEQ -- requirements
Module: usr_seq

---
 rtl/usr_seq_if.sv | 41 ++++
 rtl/usr_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/usr_seq_if.sv
// ---------------------------------------------------------------------------
// usr_seq_if -- command handshake bundle for the usr_seq shift controller.
//
// Signals
//   cmd_valid  master->slave  a command is presented this cycle
//   cmd_ready  slave->master  controller can accept a command this cycle
//   cmd_op     master->slave  00 LOAD, 01 SHR, 10 SHL, 11 ROTR
//   cmd_amt    master->slave  shift cycle count (ignored for LOAD)
//   cmd_data   master->slave  parallel load value (used only for LOAD)
//
// Modports
//   master  command issuer (drives the command, observes cmd_ready)
//   slave   usr_seq        (observes the command, drives cmd_ready)
// ---------------------------------------------------------------------------
interface usr_seq_if #(
  parameter int AMT_W = 3
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [3:0]       cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_amt,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_amt,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/usr_seq.sv
// ---------------------------------------------------------------------------
// usr_seq -- sequencer for a 4-bit universal shift register.
//
// Accepts one command at a time over a valid/ready handshake and steps an
// external 4-bit universal shift register through it by driving its mode
// select and serial inputs. An internal shadow copy (q) is updated with the
// same mode/serial values, so q always mirrors the external register.
//
// Commands: LOAD (parallel load), SHR (shift right, sin into q[3]),
// SHL (shift left, sin into q[0]), ROTR (rotate right). A shift command runs
// for exactly cmd_amt cycles; cmd_amt = 0 finishes at once with q unchanged.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (aborts any running command)
//   cmd          usr_seq_if.slave command handshake (op/amt/data)
//   sin          serial input bit, consumed on every SHR/SHL shift cycle
//   usr_sel      mode select: 00 hold, 01 right, 10 left, 11 load
//   usr_left_s   serial bit entering q[0] on a left shift, else 0
//   usr_right_s  serial bit entering q[3] on a right shift, else 0
//   q            shadow register contents
//   sout         bit leaving the register on the current shift cycle
//   sout_valid   qualifies sout (high only while shifting)
//   busy         command in progress
//   done         one-cycle completion pulse
//
// Every output is decoded from registered state; the only combinational
// input-to-output paths are sin -> usr_left_s/usr_right_s and rst gating
// cmd_ready so nothing is accepted while reset is held.
// ---------------------------------------------------------------------------
module usr_seq #(
  parameter int AMT_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  usr_seq_if.slave   cmd,
  input  logic       sin,
  output logic [1:0] usr_sel,
  output logic       usr_left_s,
  output logic       usr_right_s,
  output logic [3:0] q,
  output logic       sout,
  output logic       sout_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROTR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_RIGHT = 2'b01,
    SEL_LEFT  = 2'b10,
    SEL_LOAD  = 2'b11
  } sel_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t           r_state;
  op_t              r_op;
  logic [3:0]       r_data;
  // Loaded with the accepted cmd_amt, so it doubles as the latched amount
  // and counts down the remaining shift cycles.
  logic [AMT_W-1:0] r_cnt;
  logic [3:0]       r_q;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  state_t           w_state_nxt;
  op_t              w_cmd_op;
  logic             w_ready;
  logic             w_accept;
  logic             w_amt_zero;
  logic             w_last_shift;
  sel_t             w_sel;
  logic             w_left_s;
  logic             w_right_s;
  logic             w_sout;

  assign w_cmd_op     = op_t'(cmd.cmd_op);
  assign w_ready      = (r_state == S_IDLE) && !rst;
  assign w_accept     = cmd.cmd_valid && w_ready;
  assign w_amt_zero   = (cmd.cmd_amt == '0);
  // The count reaches zero with the shift happening this cycle.
  assign w_last_shift = (r_cnt == AMT_W'(1));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cmd_op == OP_LOAD) begin
            w_state_nxt = S_LOAD;
          end else if (w_amt_zero) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_LOAD:  w_state_nxt = S_DONE;
      S_SHIFT: if (w_last_shift) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode: mode select, serial inputs and serial output
  // -------------------------------------------------------------------------
  always_comb begin
    w_sel     = SEL_HOLD;
    w_left_s  = 1'b0;
    w_right_s = 1'b0;
    w_sout    = 1'b0;
    case (r_state)
      S_LOAD: w_sel = SEL_LOAD;
      S_SHIFT: begin
        case (r_op)
          OP_SHL: begin
            w_sel    = SEL_LEFT;
            w_left_s = sin;
            w_sout   = r_q[3];
          end
          OP_ROTR: begin
            // Rotate is a right shift that feeds the outgoing bit back in.
            w_sel     = SEL_RIGHT;
            w_right_s = r_q[0];
            w_sout    = r_q[0];
          end
          default: begin
            // OP_SHR; OP_LOAD never reaches S_SHIFT.
            w_sel     = SEL_RIGHT;
            w_right_s = sin;
            w_sout    = r_q[0];
          end
        endcase
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, command latch, counter and shadow register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_LOAD;
      r_data  <= 4'b0000;
      r_cnt   <= '0;
      r_q     <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_op   <= w_cmd_op;
        r_data <= cmd.cmd_data;
        r_cnt  <= cmd.cmd_amt;
      end else if (r_state == S_SHIFT) begin
        r_cnt  <= r_cnt - AMT_W'(1);
      end

      // The shadow register behaves exactly like the external one: it is
      // driven by the same mode select and serial inputs.
      case (w_sel)
        SEL_LOAD:  r_q <= r_data;
        SEL_RIGHT: r_q <= {w_right_s, r_q[3:1]};
        SEL_LEFT:  r_q <= {r_q[2:0], w_left_s};
        default:   r_q <= r_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cmd.cmd_ready = w_ready;
  assign usr_sel       = w_sel;
  assign usr_left_s    = w_left_s;
  assign usr_right_s   = w_right_s;
  assign q             = r_q;
  assign sout          = w_sout;
  assign sout_valid    = (r_state == S_SHIFT);
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);

endmodule
